// File: rtl/mc_control.sv
// Multi-cycle MIPS-subset control unit: instruction decode plus the FETCH..WB sequencer,
// with a down-counter that sets how long the FSM waits in MDU_WAIT for the multiply/divide unit.
module mc_control #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        eq,
  input  logic        mem_ready,
  output logic        PcWe,
  output logic        IrWe,
  output logic        WeGrf,
  output logic        WeDm,
  output logic [1:0]  RegDst,
  output logic [1:0]  WhichtoReg,
  output logic        AluSrc,
  output logic [2:0]  AluOp,
  output logic        sign,
  output logic        branch,
  output logic        JType,
  output logic        jr,
  output logic        MduStart,
  output logic [1:0]  MduOp,
  output logic        busy,
  output logic [2:0]  state
);

  // state    | meaning
  // FETCH    | load IR, PC <= PC+4
  // DECODE   | resolve jumps, filter no-ops
  // EXEC     | ALU / branch resolve / MDU launch
  // MEM      | wait for data memory
  // WB       | register-file write
  // MDU_WAIT | count down MDU latency
  localparam logic [2:0] FETCH    = 3'd0;
  localparam logic [2:0] DECODE   = 3'd1;
  localparam logic [2:0] EXEC     = 3'd2;
  localparam logic [2:0] MEM      = 3'd3;
  localparam logic [2:0] WB       = 3'd4;
  localparam logic [2:0] MDU_WAIT = 3'd5;

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [5:0] op, fn;
  logic rtype, nop_word;
  logic is_addu, is_subu, is_ori, is_lw, is_sw, is_beq, is_lui;
  logic is_j, is_jal, is_jr, is_mult, is_div, is_mfhi, is_mflo;
  logic is_jump, is_md, is_wb, valid;

  assign op       = instr[31:26];
  assign fn       = instr[5:0];
  assign rtype    = (op == 6'h00);
  assign nop_word = (instr == 32'd0);

  assign is_addu = rtype && (fn == 6'h21);
  assign is_subu = rtype && (fn == 6'h23);
  assign is_jr   = rtype && (fn == 6'h08);
  assign is_mult = rtype && (fn == 6'h18);
  assign is_div  = rtype && (fn == 6'h1a);
  assign is_mfhi = rtype && (fn == 6'h10);
  assign is_mflo = rtype && (fn == 6'h12);
  assign is_ori  = (op == 6'h0d);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2b);
  assign is_beq  = (op == 6'h04);
  assign is_lui  = (op == 6'h0f);
  assign is_j    = (op == 6'h02);
  assign is_jal  = (op == 6'h03);

  assign is_jump = is_j | is_jal | is_jr;
  assign is_md   = is_mult | is_div;
  assign is_wb   = is_addu | is_subu | is_ori | is_lui | is_mfhi | is_mflo;
  assign valid   = !nop_word &&
                   (is_jump | is_md | is_wb | is_lw | is_sw | is_beq);

  // Datapath selects depend only on the instruction word.
  always_comb begin
    RegDst     = is_jal ? 2'b10 : (is_ori | is_lw | is_lui) ? 2'b01 : 2'b00;
    WhichtoReg = is_lw ? 2'b01 : is_jal ? 2'b10 : (is_mfhi | is_mflo) ? 2'b11 : 2'b00;
    AluSrc     = is_ori | is_lw | is_sw | is_lui;
    sign       = is_lw | is_sw | is_beq;
    AluOp      = (is_subu | is_beq) ? 3'b001 : is_ori ? 3'b011 : is_lui ? 3'b100 : 3'b000;
    MduOp      = is_div ? 2'b01 : is_mfhi ? 2'b10 : is_mflo ? 2'b11 : 2'b00;
  end

  logic [2:0]       nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic pc_we, ir_we, we_grf, we_dm, br, jt, jrs, ms, bz;

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    we_grf  = 1'b0;
    we_dm   = 1'b0;
    br      = 1'b0;
    jt      = 1'b0;
    jrs     = 1'b0;
    ms      = 1'b0;
    bz      = 1'b0;
    case (state)
      FETCH: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
        nxt   = DECODE;
      end
      DECODE: begin
        if (is_jump) begin
          pc_we  = 1'b1;
          jt     = is_j | is_jal;
          jrs    = is_jr;
          we_grf = is_jal;
          nxt    = FETCH;
        end else begin
          nxt = valid ? EXEC : FETCH;
        end
      end
      EXEC: begin
        if (is_beq) begin
          br    = eq;
          pc_we = eq;
          nxt   = FETCH;
        end else if (is_lw | is_sw) begin
          nxt = MEM;
        end else if (is_md) begin
          ms      = 1'b1;
          cnt_nxt = is_mult ? MULT_CNT : DIV_CNT;
          nxt     = MDU_WAIT;
        end else begin
          nxt = is_wb ? WB : FETCH;
        end
      end
      MEM: begin
        if (mem_ready) begin
          we_dm = is_sw;
          nxt   = is_lw ? WB : FETCH;
        end
      end
      WB: begin
        we_grf = 1'b1;
        nxt    = FETCH;
      end
      MDU_WAIT: begin
        bz = 1'b1;
        // Exit at 1 so the counter never wraps through zero.
        if (cnt <= CNT_ONE) begin
          cnt_nxt = '0;
          nxt     = FETCH;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Enables are gated by reset so nothing fires while held, regardless of clk.
  assign PcWe     = reset & pc_we;
  assign IrWe     = reset & ir_we;
  assign WeGrf    = reset & we_grf;
  assign WeDm     = reset & we_dm;
  assign branch   = reset & br;
  assign JType    = reset & jt;
  assign jr       = reset & jrs;
  assign MduStart = reset & ms;
  assign busy     = reset & bz;

endmodule
